// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the keypad calculator sequencer: FSM state encoding,
// key codes, register-file addresses, ALU operation encodings and small
// key-classification helpers.
// -----------------------------------------------------------------------------
package calc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GOT_A  = 3'd1,
        ST_GOT_OP = 3'd2,
        ST_GOT_B  = 3'd3,
        ST_EXEC   = 3'd4,
        ST_WB     = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    // Default key codes for the two command keys.
    localparam logic [3:0] KEY_EQ_CODE  = 4'hE;
    localparam logic [3:0] KEY_CLR_CODE = 4'hF;

    // Register-file slots used by the sequencer (R3 is never written).
    localparam logic [1:0] REG_A   = 2'd0;
    localparam logic [1:0] REG_B   = 2'd1;
    localparam logic [1:0] REG_RES = 2'd2;

    // ALU_Sel encodings.
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    function automatic logic is_digit(input logic [3:0] code);
        return (code <= 4'd9);
    endfunction

    function automatic logic is_op_key(input logic [3:0] code);
        return (code >= 4'hA) && (code <= 4'hD);
    endfunction

    // Keys A..D map onto the four ALU operations in order.
    function automatic logic [1:0] key_to_op(input logic [3:0] code);
        logic [1:0] op;
        case (code)
            4'hA:    op = ALU_ADD;
            4'hB:    op = ALU_SUB;
            4'hC:    op = ALU_AND;
            default: op = ALU_OR;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/idle_timer.sv
// -----------------------------------------------------------------------------
// idle_timer
// Saturating idle counter. Counts clock cycles while 'run' is high and 'clear'
// is low; any clear (or run low) restarts it from zero. 'expired' is high in
// the cycle where the count equals max-1, so with max=N the N-th consecutive
// idle cycle is the expiry cycle. max=0 disables expiry entirely.
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   synchronous active-high reset
//   clear    in   restart the count from zero
//   run      in   count enable
//   max      in   timeout length in cycles (0 = never)
//   expired  out  timeout reached this cycle
// -----------------------------------------------------------------------------
module idle_timer #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             run,
    input  logic [WIDTH-1:0] max,
    output logic             expired
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || clear || !run) begin
            r_count <= '0;
        end else if (r_count != '1) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expired = run && (max != '0) && (r_count == (max - 1'b1));

endmodule

// File: rtl/calc_sequencer.sv
// -----------------------------------------------------------------------------
// calc_sequencer
// Control FSM for the keypad -> register bank -> ALU calculator. Consumes key
// events from the keypad encoder, writes operand A to R0 and operand B to R1,
// runs the ALU and writes the result to R2, and drives the register-file read
// addresses and ALU_Sel.
// Ports:
//   clk, reset         clock / synchronous active-high reset
//   key_valid,key_code one-cycle key event and its code
//   alu_result,alu_zero ALU output and zero flag (combinational from raddrs)
//   rf_we,rf_waddr     register-file write strobe and address
//   rf_wsel            write-data mux: 0 = key digit, 1 = alu_result
//   rf_raddr_a/b       register-file read addresses
//   alu_sel            ALU operation select
//   busy               high in EXEC/WB; keys are dropped
//   result_valid       high in DONE
//   result, zero       values latched in WB
//   err                sticky misplaced-EQ flag, cleared by next accepted key
// -----------------------------------------------------------------------------
module calc_sequencer
    import calc_pkg::*;
#(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000,
    parameter logic [3:0]  KEY_EQ         = KEY_EQ_CODE,
    parameter logic [3:0]  KEY_CLR        = KEY_CLR_CODE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic [7:0] alu_result,
    input  logic       alu_zero,
    output logic       rf_we,
    output logic [1:0] rf_waddr,
    output logic       rf_wsel,
    output logic [1:0] rf_raddr_a,
    output logic [1:0] rf_raddr_b,
    output logic [1:0] alu_sel,
    output logic       busy,
    output logic       result_valid,
    output logic [7:0] result,
    output logic       zero,
    output logic       err
);

    state_t     r_state;
    state_t     w_state_next;
    logic [1:0] r_op;
    logic [1:0] w_op_next;
    logic [1:0] r_a_src;
    logic [1:0] w_a_src_next;
    logic       r_err;
    logic       w_err_next;
    logic [7:0] r_result;
    logic       r_zero;

    logic       w_is_digit;
    logic       w_is_eq;
    logic       w_is_clr;
    logic       w_is_op;
    logic       w_expired;
    logic       w_timer_run;
    logic       w_timer_clear;

    assign w_is_eq    = (key_code == KEY_EQ);
    assign w_is_clr   = (key_code == KEY_CLR);
    assign w_is_digit = is_digit(key_code) && !w_is_eq && !w_is_clr;
    assign w_is_op    = is_op_key(key_code) && !w_is_eq && !w_is_clr;

    // Only the operand-entry states time out; DONE and IDLE wait forever.
    assign w_timer_run   = (r_state == ST_GOT_A) || (r_state == ST_GOT_OP) ||
                           (r_state == ST_GOT_B);
    assign w_timer_clear = key_valid || (w_state_next != r_state);

    idle_timer #(
        .WIDTH (24)
    ) u_idle_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_timer_clear),
        .run     (w_timer_run),
        .max     (TIMEOUT_CYCLES),
        .expired (w_expired)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic, plus next values of the operation/source/err context
    // that travels with the state.
    always_comb begin
        w_state_next = r_state;
        w_op_next    = r_op;
        w_a_src_next = r_a_src;
        w_err_next   = r_err;
        case (r_state)
            ST_EXEC: w_state_next = ST_WB;
            ST_WB:   w_state_next = ST_DONE;
            default: begin
                if (key_valid) begin
                    if (w_is_clr) begin
                        w_state_next = ST_IDLE;
                        w_err_next   = 1'b0;
                    end else begin
                        case (r_state)
                            ST_IDLE: begin
                                if (w_is_digit) begin
                                    w_state_next = ST_GOT_A;
                                    w_err_next   = 1'b0;
                                end else if (w_is_eq) begin
                                    w_err_next = 1'b1;
                                end
                            end
                            ST_GOT_A: begin
                                if (w_is_digit) begin
                                    w_err_next = 1'b0;
                                end else if (w_is_op) begin
                                    w_op_next    = key_to_op(key_code);
                                    w_a_src_next = REG_A;
                                    w_state_next = ST_GOT_OP;
                                    w_err_next   = 1'b0;
                                end else if (w_is_eq) begin
                                    w_err_next = 1'b1;
                                end
                            end
                            ST_GOT_OP: begin
                                if (w_is_op) begin
                                    w_op_next  = key_to_op(key_code);
                                    w_err_next = 1'b0;
                                end else if (w_is_digit) begin
                                    w_state_next = ST_GOT_B;
                                    w_err_next   = 1'b0;
                                end else if (w_is_eq) begin
                                    w_err_next = 1'b1;
                                end
                            end
                            ST_GOT_B: begin
                                if (w_is_digit) begin
                                    w_err_next = 1'b0;
                                end else if (w_is_eq) begin
                                    w_state_next = ST_EXEC;
                                    w_err_next   = 1'b0;
                                end
                            end
                            ST_DONE: begin
                                if (w_is_digit) begin
                                    w_a_src_next = REG_A;
                                    w_state_next = ST_GOT_A;
                                    w_err_next   = 1'b0;
                                end else if (w_is_op) begin
                                    // Chain: the previous result becomes operand A.
                                    w_op_next    = key_to_op(key_code);
                                    w_a_src_next = REG_RES;
                                    w_state_next = ST_GOT_OP;
                                    w_err_next   = 1'b0;
                                end else if (w_is_eq) begin
                                    w_state_next = ST_EXEC;
                                    w_err_next   = 1'b0;
                                end
                            end
                            default: ;
                        endcase
                    end
                end else if (w_expired) begin
                    w_state_next = ST_IDLE;
                    w_err_next   = 1'b0;
                end
            end
        endcase
    end

    // Context and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op     <= ALU_ADD;
            r_a_src  <= REG_A;
            r_err    <= 1'b0;
            r_result <= 8'd0;
            r_zero   <= 1'b0;
        end else begin
            r_op    <= w_op_next;
            r_a_src <= w_a_src_next;
            r_err   <= w_err_next;
            if (r_state == ST_WB) begin
                r_result <= alu_result;
                r_zero   <= alu_zero;
            end
        end
    end

    // Output logic. Everything is forced low while reset is asserted so a
    // reset landing in WB cannot complete the R2 write in that cycle.
    always_comb begin
        rf_we        = 1'b0;
        rf_waddr     = REG_A;
        rf_wsel      = 1'b0;
        rf_raddr_a   = 2'd0;
        rf_raddr_b   = 2'd0;
        alu_sel      = 2'd0;
        busy         = 1'b0;
        result_valid = 1'b0;
        if (!reset) begin
            // Read addresses track the context live; it is stable in EXEC/WB.
            rf_raddr_a   = r_a_src;
            rf_raddr_b   = REG_B;
            alu_sel      = r_op;
            busy         = (r_state == ST_EXEC) || (r_state == ST_WB);
            result_valid = (r_state == ST_DONE);
            case (r_state)
                ST_EXEC: ;
                ST_WB: begin
                    rf_we    = 1'b1;
                    rf_waddr = REG_RES;
                    rf_wsel  = 1'b1;
                end
                default: begin
                    if (key_valid && w_is_digit) begin
                        rf_we    = 1'b1;
                        rf_waddr = ((r_state == ST_GOT_OP) || (r_state == ST_GOT_B))
                                   ? REG_B : REG_A;
                    end
                end
            endcase
        end
    end

    assign result = r_result;
    assign zero   = r_zero;
    assign err    = r_err;

endmodule
